insn_fetch_unit: RTL

Owns the program counter and the instruction register of the RV32I core and sequences each instruction through FETCH and EXECUTE phases. It fetches from instruction memory with a req/ack handshake and presents a stable `insn` plus an `insn_valid` strobe to the per-format instruction decoders. On leaving EXECUTE it consumes their `pc_next_sel` / `pc_alu_sel` outputs to compute the next PC. It sits directly upstream of the decoders (feeds `insn`) and also consumes their PC-control outputs.

---
 rtl/insn_fetch_unit.sv | 88 ++++++++
 1 files changed

// File: rtl/insn_fetch_unit.sv
// Program counter and instruction register for the RV32I core: sequences each
// instruction through FETCH (imem req/ack) and EXECUTE, then computes the next PC.
module insn_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] insn,
  output logic        insn_valid,
  output logic [31:0] pc,
  input  logic        pc_next_sel,
  input  logic        pc_alu_sel,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        stall,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  // Handshake: imem_req stays high with a stable imem_addr until a cycle in
  // which imem_ack is high; that rising edge captures imem_rdata and ends FETCH.
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] insn_q;
  logic        halted_q;
  logic [31:0] pc_alu_d;
  logic [31:0] target_d;

  always_comb begin
    pc_alu_d = pc_q + (pc_alu_sel ? imm : 32'd4);
    target_d = pc_next_sel ? {alu_result[31:1], 1'b0} : pc_alu_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      insn_q   <= NOP_INSN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            insn_q  <= imem_rdata;
            state_q <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (!stall) begin
            // A misaligned target freezes the PC at the offending instruction.
            if (target_d[1:0] != 2'b00) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q    <= target_d;
              state_q <= ST_FETCH;
            end
          end
        end
        default: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // Strobes come from registered state only; reset masks them immediately.
  assign imem_req   = (state_q == ST_FETCH) && !reset;
  assign insn_valid = (state_q == ST_EXECUTE) && !reset;
  assign halted     = halted_q && !reset;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign insn       = insn_q;
  assign dbg_state  = state_q;

endmodule
